line_raster: RTL and testbench
==============================

Name: line_raster

Overview:
- Bresenham line rasteriser sitting directly downstream of the AHB output slave.
- Consumes that slave's endpoint registers (x1, y1, x2, y2, DataValid) and emits one pixel coordinate per accepted handshake, running from (x1,y1) to (x2,y2) inclusive.
- Feeds the pixel write/display stage.
- Provides a one-entry pending buffer so software may queue the next line while the current one is still drawing.

Parameters:
- CW, 9, coordinate width in bits (screen 0..2^CW-1)

Ports:
- HCLK  input  1  system clock; all logic on rising edge
- HRESET  input  1  synchronous, active-high reset
- x1  input  CW  line start X
- y1  input  CW  line start Y
- x2  input  CW  line end X
- y2  input  CW  line end Y
- DataValid  input  1  endpoints valid; each rising edge is one line request
- PixelX  output  CW  current pixel X
- PixelY  output  CW  current pixel Y
- PixelValid  output  1  PixelX/PixelY valid
- PixelReady  input  1  downstream accepts the pixel when PixelValid && PixelReady
- Busy  output  1  line in progress or pending entry held
- LineDone  output  1  one-cycle pulse after the last pixel of a line is accepted
- Overflow  output  1  sticky; a request was dropped

Behaviour:
- Reset (HRESET high at a clock edge) values: PixelX=0, PixelY=0, PixelValid=0, Busy=0, LineDone=0, Overflow=0, state=IDLE, pending empty, DataValid edge register=0. Reset mid-line aborts the line with no LineDone.
- Request detection: req = DataValid && !DataValid_q, where DataValid_q is registered. On req, x1/y1/x2/y2 are sampled that same cycle.
- Request routing:
  - IDLE: request loads the working registers.
  - Otherwise, with the pending buffer empty: request is stored in pending.
  - Otherwise, with pending full: request is dropped and Overflow is set. Overflow is cleared only by reset.
- FSM states: IDLE, SETUP, DRAW.
  - IDLE -> SETUP on req, or when pending is full; pending has priority and is then emptied.
  - SETUP (1 cycle) computes, in signed CW+2 bits:
    - dx = |x2-x1|, sx = (x1<x2) ? +1 : -1
    - dy = -|y2-y1|, sy = (y1<y2) ? +1 : -1
    - err = dx+dy
    - loads PixelX=x1, PixelY=y1
    - asserts PixelValid -> DRAW
  - DRAW: PixelValid=1. Outputs hold stable while !PixelReady. On accept:
    - If (PixelX,PixelY)==(x2,y2): PixelValid=0, LineDone=1 next cycle, then -> SETUP if pending is full, else -> IDLE.
    - Else, with e2=2*err:
      - if e2>=dy: err+=dy, PixelX+=sx
      - if e2<=dx: err+=dx, PixelY+=sy
      - both adjustments may apply in the same step and use the pre-step err
      - next pixel is valid the following cycle, so back-to-back acceptance gives 1 pixel/cycle.
- Latency: req at cycle N -> first PixelValid at cycle N+2 (IDLE case).
- Pixel count: exactly max(|x2-x1|,|y2-y1|)+1. Degenerate line (x1==x2, y1==y2) emits one pixel.
- No wrap-around: coordinates stay within the inclusive endpoint box. A request arriving in the same cycle that pending is consumed is stored, since pending is freed first.
- Busy = (state!=IDLE) || pending full.

Decomposition:
- Shared package line_pkg:
  - typedef coord_t (logic [CW-1:0])
  - typedef err_t (signed [CW+1:0])
  - enum state_t {IDLE, SETUP, DRAW}
  - struct line_req_t {x1, y1, x2, y2}
- One natural sub-module, line_req_buf: edge detect plus single-entry pending register, with outputs req_valid/req_data and input req_take. The FSM and datapath stay in line_raster.

Test Plan:
- Horizontal line (3,5)->(7,5), PixelReady=1:
  - pixels (3,5),(4,5),(5,5),(6,5),(7,5) on consecutive cycles
  - first pixel 2 cycles after the DataValid edge
  - LineDone one cycle after (7,5).
- Steep reverse line (10,10)->(8,4): 7 pixels, Y decreasing 10..4 and X stepping from 10 down to 8, matching a Bresenham reference model; ends exactly at (8,4).
- Degenerate line (100,200)->(100,200): single pixel, then LineDone; Busy low 2 cycles after LineDone.
- Backpressure on (0,0)->(3,3): PixelReady toggled 1,0,0,1,...; each pixel stays stable while stalled; sequence (0,0),(1,1),(2,2),(3,3) with no loss or duplication.
- Queueing and overflow:
  - three DataValid edges during a 20-pixel line: 2nd is drawn immediately after the 1st with no IDLE gap; 3rd is dropped and Overflow=1.
  - HRESET high during DRAW: all outputs reset next cycle, no LineDone, and Overflow cleared.

Source files
------------

// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_pkg
// Description : Shared types for the Bresenham line rasteriser: coordinate
//               and error types, FSM state encoding, line request record and
//               an absolute-difference helper.
// Revision    : 1.0 - initial release
// ============================================================================
package line_pkg;

    // Coordinate width; the rasteriser's CW parameter defaults to this value
    // and must track it, since all internal types are built from it.
    localparam int LINE_CW = 9;

    typedef logic [LINE_CW-1:0]        coord_t;
    // Two extra bits: one for sign, one so 2*err cannot overflow.
    typedef logic signed [LINE_CW+1:0] err_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    typedef struct packed {
        coord_t x1;
        coord_t y1;
        coord_t x2;
        coord_t y2;
    } line_req_t;

    // |a-b| zero-extended into the signed error type.
    function automatic err_t abs_diff(input coord_t a, input coord_t b);
        coord_t w_d;
        w_d = (a >= b) ? (a - b) : (b - a);
        return err_t'({2'b00, w_d});
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_req_buf.sv
`default_nettype none
// ============================================================================
// Module      : line_req_buf
// Description : DataValid rising-edge detector plus a single-entry pending
//               line request buffer with sticky overflow flag.
//   clk, rst   : clock, synchronous active-high reset
//   data_valid : endpoint-valid level; each rising edge is one request
//   data_in    : endpoints sampled on the request cycle
//   req_take   : consumer takes the presented request this cycle
//   req_valid  : a request is presented (pending entry, else fresh edge)
//   req_data   : presented request
//   pend_full  : pending entry occupied
//   overflow   : sticky, a request was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module line_req_buf
    import line_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      data_valid,
    input  line_req_t data_in,
    input  logic      req_take,
    output logic      req_valid,
    output line_req_t req_data,
    output logic      pend_full,
    output logic      overflow
);

    logic      r_dv_q;
    logic      r_full;
    line_req_t r_pend;
    logic      r_ovf;

    logic w_edge;
    logic w_take_pend;
    logic w_take_edge;

    assign w_edge      = data_valid && !r_dv_q;
    // The pending entry always has priority over a fresh edge.
    assign w_take_pend = req_take && r_full;
    assign w_take_edge = req_take && !r_full;

    assign req_valid = r_full || w_edge;
    assign req_data  = r_full ? r_pend : data_in;
    assign pend_full = r_full;
    assign overflow  = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv_q <= 1'b0;
            r_full <= 1'b0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_dv_q <= data_valid;
            if (w_take_pend) begin
                // Slot is freed first, so a same-cycle edge refills it.
                r_full <= w_edge;
                if (w_edge) begin
                    r_pend <= data_in;
                end
            end else if (w_edge && !w_take_edge) begin
                if (!r_full) begin
                    r_full <= 1'b1;
                    r_pend <= data_in;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_raster.sv
`default_nettype none
// ============================================================================
// Module      : line_raster
// Description : Bresenham line rasteriser. Emits one pixel per accepted
//               valid/ready handshake from (x1,y1) to (x2,y2) inclusive, with
//               a one-entry queue for the next line.
//   HCLK, HRESET              : clock, synchronous active-high reset
//   x1, y1, x2, y2, DataValid : line endpoints; DataValid rising edge = request
//   PixelX, PixelY, PixelValid: current pixel
//   PixelReady                : downstream accept
//   Busy                      : line in progress or pending entry held
//   LineDone                  : pulse after last pixel of a line accepted
//   Overflow                  : sticky, a request was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module line_raster
    import line_pkg::*;
#(
    parameter int CW = LINE_CW
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    input  logic [CW-1:0] x2,
    input  logic [CW-1:0] y2,
    input  logic          DataValid,
    output logic [CW-1:0] PixelX,
    output logic [CW-1:0] PixelY,
    output logic          PixelValid,
    input  logic          PixelReady,
    output logic          Busy,
    output logic          LineDone,
    output logic          Overflow
);

    state_t    r_state;
    line_req_t r_line;
    coord_t    r_x;
    coord_t    r_y;
    err_t      r_dx;
    err_t      r_dy;
    err_t      r_err;
    logic      r_sx_pos;
    logic      r_sy_pos;
    logic      r_valid;
    logic      r_done;

    line_req_t w_in;
    logic      w_req_valid;
    line_req_t w_req_data;
    logic      w_pend_full;
    logic      w_req_take;
    logic      w_accept;
    logic      w_at_end;
    err_t      w_e2;
    logic      w_step_x;
    logic      w_step_y;
    err_t      w_err_next;

    assign w_in = '{x1: x1, y1: y1, x2: x2, y2: y2};

    line_req_buf u_req_buf (
        .clk        (HCLK),
        .rst        (HRESET),
        .data_valid (DataValid),
        .data_in    (w_in),
        .req_take   (w_req_take),
        .req_valid  (w_req_valid),
        .req_data   (w_req_data),
        .pend_full  (w_pend_full),
        .overflow   (Overflow)
    );

    assign w_accept = r_valid && PixelReady;
    assign w_at_end = (r_x == r_line.x2) && (r_y == r_line.y2);

    // Both steps are decided from the pre-step error term.
    assign w_e2       = r_err <<< 1;
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : err_t'(0))
                              + (w_step_y ? r_dx : err_t'(0));

    // A fresh edge while drawing is left to the buffer to queue; only the
    // pending entry chains straight into the next SETUP.
    assign w_req_take = ((r_state == IDLE) && w_req_valid) ||
                        ((r_state == DRAW) && w_accept && w_at_end && w_pend_full);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state  <= IDLE;
            r_line   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_pos <= 1'b0;
            r_sy_pos <= 1'b0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_valid) begin
                        r_line  <= w_req_data;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_dx     <= abs_diff(r_line.x2, r_line.x1);
                    r_dy     <= -abs_diff(r_line.y2, r_line.y1);
                    r_err    <= abs_diff(r_line.x2, r_line.x1)
                              - abs_diff(r_line.y2, r_line.y1);
                    r_sx_pos <= (r_line.x1 < r_line.x2);
                    r_sy_pos <= (r_line.y1 < r_line.y2);
                    r_x      <= r_line.x1;
                    r_y      <= r_line.y1;
                    r_valid  <= 1'b1;
                    r_state  <= DRAW;
                end
                DRAW: begin
                    if (w_accept) begin
                        if (w_at_end) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            if (w_pend_full) begin
                                r_line  <= w_req_data;
                                r_state <= SETUP;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_err <= w_err_next;
                            if (w_step_x) begin
                                r_x <= r_sx_pos ? (r_x + 1'b1) : (r_x - 1'b1);
                            end
                            if (w_step_y) begin
                                r_y <= r_sy_pos ? (r_y + 1'b1) : (r_y - 1'b1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign PixelX     = r_x;
    assign PixelY     = r_y;
    assign PixelValid = r_valid;
    assign LineDone   = r_done;
    assign Busy       = (r_state != IDLE) || w_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_line_raster.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_raster
// Description : Self-checking bench for line_raster. Stimulus pushes the
//               expected pixel stream into a scoreboard queue; a monitor pops
//               and compares on every accepted pixel and checks LineDone and
//               stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_raster;

    localparam int CW = 9;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [CW-1:0] x1, y1, x2, y2;
    logic          DataValid;
    logic [CW-1:0] PixelX, PixelY;
    logic          PixelValid;
    logic          PixelReady;
    logic          Busy;
    logic          LineDone;
    logic          Overflow;

    line_raster #(.CW(CW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .DataValid  (DataValid),
        .PixelX     (PixelX),
        .PixelY     (PixelY),
        .PixelValid (PixelValid),
        .PixelReady (PixelReady),
        .Busy       (Busy),
        .LineDone   (LineDone),
        .Overflow   (Overflow)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } px_t;

    px_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int x, input int y, input bit last);
        px_t e;
        e.x = CW'(x);
        e.y = CW'(y);
        e.last = last;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int ax, input int ay, input int bx, input int by);
        x1 = CW'(ax);
        y1 = CW'(ay);
        x2 = CW'(bx);
        y2 = CW'(by);
        DataValid = 1'b1;
        @(posedge HCLK); #1;
        DataValid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk(name, sb_q.size(), 0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!LineDone && n < 200) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk(name, {31'd0, LineDone}, 1);
    endtask

    // ---------------- monitor ----------------
    logic          hold_v = 1'b0;
    logic [CW-1:0] hold_x, hold_y;
    logic          exp_done = 1'b0;

    always @(negedge HCLK) begin
        px_t e;
        if (HRESET) begin
            hold_v   = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done || LineDone) begin
                chk("linedone", {31'd0, LineDone}, {31'd0, exp_done});
            end
            exp_done = 1'b0;
            if (hold_v) begin
                chk("stall_valid", {31'd0, PixelValid}, 1);
                chk("stall_x", {23'd0, PixelX}, {23'd0, hold_x});
                chk("stall_y", {23'd0, PixelY}, {23'd0, hold_y});
            end
            hold_v = 1'b0;
            if (PixelValid) begin
                if (PixelReady) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_pixel", {23'd0, PixelX}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pixel_x", {23'd0, PixelX}, {23'd0, e.x});
                        chk("pixel_y", {23'd0, PixelY}, {23'd0, e.y});
                        exp_done = e.last;
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_x = PixelX;
                    hold_y = PixelY;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        HRESET = 1'b1;
        DataValid = 1'b0;
        PixelReady = 1'b1;
        x1 = '0; y1 = '0; x2 = '0; y2 = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk("rst_valid", {31'd0, PixelValid}, 0);
        chk("rst_x", {23'd0, PixelX}, 0);
        chk("rst_y", {23'd0, PixelY}, 0);
        chk("rst_busy", {31'd0, Busy}, 0);
        chk("rst_done", {31'd0, LineDone}, 0);
        chk("rst_ovf", {31'd0, Overflow}, 0);
        @(posedge HCLK); #1;

        // Horizontal (3,5)->(7,5), two-cycle latency, one pixel per cycle
        for (int i = 3; i <= 7; i++) push(i, 5, i == 7);
        issue(3, 5, 7, 5);
        chk("lat_setup_valid", {31'd0, PixelValid}, 0);
        @(posedge HCLK); #1;
        for (int k = 0; k < 5; k++) begin
            chk("horiz_valid", {31'd0, PixelValid}, 1);
            chk("horiz_x", {23'd0, PixelX}, 32'(3 + k));
            @(posedge HCLK); #1;
        end
        chk("horiz_done", {31'd0, LineDone}, 1);
        repeat (3) @(posedge HCLK);
        #1;

        // Steep reverse (10,10)->(8,4)
        push(10, 10, 0); push(10, 9, 0); push(9, 8, 0); push(9, 7, 0);
        push(9, 6, 0);   push(8, 5, 0);  push(8, 4, 1);
        issue(10, 10, 8, 4);
        drain("steep_drain", 50);
        repeat (3) @(posedge HCLK);
        #1;

        // Degenerate (100,200)->(100,200)
        push(100, 200, 1);
        issue(100, 200, 100, 200);
        wait_done("degen_done");
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        chk("degen_busy", {31'd0, Busy}, 0);
        chk("degen_drain", sb_q.size(), 0);

        // Backpressure (0,0)->(3,3), ready pattern 1,0,0,1,0,0...
        for (int i = 0; i <= 3; i++) push(i, i, i == 3);
        issue(0, 0, 3, 3);
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            PixelReady = (i % 3 == 0);
            @(posedge HCLK); #1;
        end
        PixelReady = 1'b1;
        chk("bp_drain", sb_q.size(), 0);
        repeat (3) @(posedge HCLK);
        #1;

        // Queueing: 20-pixel line, second queued, third dropped
        for (int i = 0; i < 20; i++) push(i, 0, i == 19);
        push(50, 60, 0); push(51, 60, 0); push(52, 60, 1);
        issue(0, 0, 19, 0);
        @(posedge HCLK); #1;
        issue(50, 60, 52, 60);
        chk("q_ovf_clear", {31'd0, Overflow}, 0);
        @(posedge HCLK); #1;
        issue(200, 200, 201, 201);
        chk("q_ovf_set", {31'd0, Overflow}, 1);
        chk("q_busy", {31'd0, Busy}, 1);
        wait_done("q_first_done");
        chk("q_busy_gap", {31'd0, Busy}, 1);
        @(posedge HCLK); #1;
        chk("q_chain_valid", {31'd0, PixelValid}, 1);
        chk("q_chain_x", {23'd0, PixelX}, 50);
        drain("q_drain", 50);
        repeat (3) @(posedge HCLK);
        #1;
        chk("q_idle", {31'd0, Busy}, 0);
        chk("q_ovf_sticky", {31'd0, Overflow}, 1);

        // Reset during DRAW
        for (int i = 0; i <= 30; i++) push(i, 0, i == 30);
        issue(0, 0, 30, 0);
        repeat (5) @(posedge HCLK);
        #1;
        chk("mid_valid_before", {31'd0, PixelValid}, 1);
        HRESET = 1'b1;
        sb_q.delete();
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        chk("mid_rst_valid", {31'd0, PixelValid}, 0);
        chk("mid_rst_x", {23'd0, PixelX}, 0);
        chk("mid_rst_busy", {31'd0, Busy}, 0);
        chk("mid_rst_ovf", {31'd0, Overflow}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("mid_no_done", {31'd0, LineDone}, 0);
            @(posedge HCLK); #1;
        end
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
